// File: rtl/brick_reader_pkg.sv
// Shared constants for the brick reader: build-time brick count, health colours,
// reader FSM encodings and the brick grid geometry used by address_xy.
package brick_reader_pkg;

  localparam int unsigned BRICKNUM = 40;

  localparam logic [2:0] COL_H3   = 3'b100;
  localparam logic [2:0] COL_H2   = 3'b110;
  localparam logic [2:0] COL_H1   = 3'b010;
  localparam logic [2:0] COL_DEAD = 3'b000;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ   = 3'd1;
  localparam logic [2:0] S_CHECK  = 3'd2;
  localparam logic [2:0] S_DRAW   = 3'd3;
  localparam logic [2:0] S_NEXT   = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  // Bricks are laid out row-major, BRICK_COLS per row, starting at pixel row GRID_Y0.
  localparam logic [9:0] BRICK_COLS = 10'd10;
  localparam logic [9:0] BRICK_W    = 10'd16;
  localparam logic [9:0] BRICK_H    = 10'd8;
  localparam logic [9:0] GRID_Y0    = 10'd16;

  function automatic logic [2:0] health_colour(input logic [1:0] health);
    logic [2:0] col;
    case (health)
      2'd3:    col = COL_H3;
      2'd2:    col = COL_H2;
      2'd1:    col = COL_H1;
      default: col = COL_DEAD;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/address_xy.sv
// Converts a brick RAM address into the top-left pixel position of that brick.
module address_xy
  import brick_reader_pkg::*;
(
  input  logic [9:0] address,
  output logic [9:0] x,
  output logic [9:0] y
);

  logic [9:0] col;
  logic [9:0] row;

  assign col = address % BRICK_COLS;
  assign row = address / BRICK_COLS;
  assign x   = col * BRICK_W;
  assign y   = GRID_Y0 + row * BRICK_H;

endmodule

// File: rtl/brick_reader_control.sv
// Scan FSM for the brick reader: sequences read, check, draw handshake and
// next-address steps, and emits strobes that drive the datapath in brick_reader.
module brick_reader_control
  import brick_reader_pkg::*;
#(
  parameter int unsigned ERASE_DEAD = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic live,
  input  logic last_index,
  input  logic draw_ack,
  output logic scan_init,
  output logic load_health,
  output logic count_inc,
  output logic index_inc,
  output logic finish,
  output logic draw_req,
  output logic busy,
  output logic done
);

  logic [2:0] state;
  logic [2:0] state_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    scan_init   = 1'b0;
    load_health = 1'b0;
    count_inc   = 1'b0;
    index_inc   = 1'b0;
    finish      = 1'b0;
    draw_req    = 1'b0;
    done        = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) begin
          scan_init  = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ: state_next = S_CHECK;
      S_CHECK: begin
        load_health = 1'b1;
        if (live) begin
          count_inc  = 1'b1;
          state_next = S_DRAW;
        end else if (ERASE_DEAD != 0) begin
          state_next = S_DRAW;
        end else begin
          state_next = S_NEXT;
        end
      end
      S_DRAW: begin
        draw_req = 1'b1;
        if (draw_ack) state_next = S_NEXT;
      end
      S_NEXT: begin
        if (last_index) begin
          state_next = S_FINISH;
        end else begin
          index_inc  = 1'b1;
          state_next = S_READ;
        end
      end
      S_FINISH: begin
        done       = 1'b1;
        finish     = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: rtl/brick_reader.sv
// Walks brick RAM, asks the shared drawer to paint every live brick and reports
// the live-brick count and level-clear status of the last completed scan.
module brick_reader
  import brick_reader_pkg::*;
#(
  parameter int unsigned BRICK_NUM  = BRICKNUM,
  parameter int unsigned ERASE_DEAD = 0
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  output logic [9:0] rd_address,
  input  logic [1:0] rd_health,
  output logic       draw_req,
  input  logic       draw_ack,
  output logic [9:0] x_out,
  output logic [9:0] y_out,
  output logic [2:0] colour,
  output logic       busy,
  output logic       done,
  output logic [9:0] bricks_left,
  output logic       level_clear
);

  localparam logic [9:0] LAST_INDEX = 10'(BRICK_NUM - 1);

  logic [9:0] index;
  logic [9:0] count;
  logic [1:0] health_r;
  logic       scan_init;
  logic       load_health;
  logic       count_inc;
  logic       index_inc;
  logic       finish;

  brick_reader_control #(
    .ERASE_DEAD (ERASE_DEAD)
  ) u_control (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .live        (rd_health != 2'd0),
    .last_index  (index == LAST_INDEX),
    .draw_ack    (draw_ack),
    .scan_init   (scan_init),
    .load_health (load_health),
    .count_inc   (count_inc),
    .index_inc   (index_inc),
    .finish      (finish),
    .draw_req    (draw_req),
    .busy        (busy),
    .done        (done)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      index       <= '0;
      count       <= '0;
      health_r    <= '0;
      bricks_left <= '0;
      level_clear <= 1'b0;
    end else begin
      if (scan_init) begin
        index <= '0;
        count <= '0;
      end
      if (index_inc) index <= index + 10'd1;
      if (load_health) health_r <= rd_health;
      // Saturate rather than wrap so an oversized build never reports a clear level.
      if (count_inc && (count != '1)) count <= count + 10'd1;
      if (finish) begin
        bricks_left <= count;
        level_clear <= (count == '0);
      end
    end
  end

  assign rd_address = index;
  assign colour     = health_colour(health_r);

  address_xy u_address_xy (
    .address (index),
    .x       (x_out),
    .y       (y_out)
  );

endmodule

// File: doc/brick_reader.md
Name: brick_reader

Overview:
- Reader-side counterpart to the level loader; the loader writes brick health into brick RAM.
- On `start`, walks brick RAM from address 0 to BRICK_NUM-1 and reads each entry (synchronous RAM, 1-cycle read latency).
- For each live brick (health != 0), issues a draw request to the shared drawer with x/y and a health-derived colour, and waits for the acknowledge.
- Counts live bricks. Reports `done` and `level_clear`, used by the top-level game FSM for redraw after a hit and for win detection.

Parameters:
- BRICK_NUM, 40, number of brick RAM entries scanned (top level passes `BRICKNUM).
- ERASE_DEAD, 0, if 1, dead bricks (health 0) are also drawn, with colour 3'b000.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle scan request; sampled only in S_IDLE
- rd_address  out  10  brick RAM read address
- rd_health  in  2  brick RAM read data; valid the cycle after rd_address is presented
- draw_req  out  1  level request to drawer
- draw_ack  in  1  drawer finished current brick
- x_out  out  10  brick pixel x, from address_xy(rd_address)
- y_out  out  10  brick pixel y, from address_xy(rd_address)
- colour  out  3  draw colour
- busy  out  1  high in every state except S_IDLE
- done  out  1  one-cycle pulse at end of scan
- bricks_left  out  10  live-brick count from the last completed scan
- level_clear  out  1  high when the last completed scan found 0 live bricks

Behaviour:
- Reset (async, resetn=0):
  - state = S_IDLE.
  - index, bricks_left, internal count, health_r are all 0.
  - draw_req, done, busy, level_clear, colour are all 0.
  - rd_address = 0; x_out/y_out = address_xy(0).
- rd_address = index register. x_out/y_out are combinational from index via address_xy, so they are stable whenever index is stable.
- States:
  - S_IDLE: if start, then index <= 0, count <= 0, go to S_READ.
  - S_READ: address presented; go to S_CHECK.
  - S_CHECK: health_r <= rd_health.
    - If rd_health != 0: count <= count+1, go to S_DRAW.
    - Else if ERASE_DEAD: go to S_DRAW.
    - Else: go to S_NEXT.
  - S_DRAW: draw_req = 1. Stay until draw_ack = 1 is sampled in this state, then go to S_NEXT. An ack in the first S_DRAW cycle is accepted.
  - S_NEXT: if index == BRICK_NUM-1, go to S_FINISH; else index <= index+1 and go to S_READ.
  - S_FINISH: done = 1 for this one cycle; bricks_left <= count; level_clear <= (count == 0); go to S_IDLE.
- Colour is taken from registered health_r:
  - 3 -> 3'b100
  - 2 -> 3'b110
  - 1 -> 3'b010
  - 0 -> 3'b000
- colour, x_out, y_out and rd_address are held stable for the whole time draw_req is high.
- Timing: a scan with no draws takes 3 cycles per brick. done is high 3*BRICK_NUM+1 cycles after the clock edge that samples start. Each draw adds (cycles in S_DRAW).
- Boundaries:
  - start while busy: ignored.
  - draw_ack outside S_DRAW: ignored.
  - BRICK_NUM=1: S_NEXT goes directly to S_FINISH.
  - index never exceeds BRICK_NUM-1 and never wraps.
  - bricks_left and level_clear update only in S_FINISH; partial counts are never visible.
  - count saturates at 1023; it cannot overflow for BRICK_NUM <= 1023.
  - resetn low mid-scan (including mid-draw): draw_req drops immediately and the block returns to the reset state. The next start rescans from address 0.
  - start high in the S_FINISH cycle: not sampled; it is sampled in the next S_IDLE cycle.

Decomposition:
- macros.v gets:
  - `BRICKNUM
  - colour constants `COL_H3 / `COL_H2 / `COL_H1 / `COL_DEAD
  - 3-bit state encodings for brick_reader
- Reuse the existing address_xy module for the address -> x/y conversion.
- One natural new sub-module: brick_reader_control (FSM), with the datapath (index, count, health_r, colour) kept in brick_reader. This mirrors the control/datapath split used by the loader.

Test Plan:
- BRICK_NUM=4, RAM all 0, start pulse -> no draw_req; done in cycle 13; bricks_left=0; level_clear=1.
- RAM {3,0,1,2}, draw_ack 2 cycles after each req -> draw_req at addresses 0, 2, 3 with colours 100, 010, 110; bricks_left=3; level_clear=0.
- RAM {2,...}, draw_ack held low 50 cycles -> draw_req stays high; rd_address=0, colour=110, x/y constant; index does not advance.
- start re-pulsed during S_DRAW and S_READ -> no restart; exactly one done pulse; results same as a single start.
- resetn low while draw_req=1 -> draw_req=0 and busy=0 immediately; then start -> first rd_address=0.
- ERASE_DEAD=1, BRICK_NUM=2, RAM {0,2} -> two draw_req, colours 000 then 110; bricks_left=1.
